mtr_duty_slew: RTL and testbench

Converts signed left/right wheel-speed commands into slew-limited 11-bit duty values for the two downstream 11-bit PWM generators (one per motor H-bridge). Duty changes are applied only at PWM period boundaries, stepping by at most STEP counts per period, so that no pulse is truncated and current inrush is bounded. It sits between the motion controller (speed commands) and the PWM stage. Duty 0x400 (50%, complementary drive) is zero torque.

---
 rtl/mtr_pkg.sv | 8 +
 rtl/mtr_duty_slew_if.sv | 23 ++
 rtl/mtr_duty_slew_chan.sv | 49 ++++
 rtl/mtr_duty_slew.sv | 48 ++++
 tb/tb_mtr_duty_slew.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/mtr_pkg.sv
// Shared widths and duty constants for the wheel-motor duty slew block.
// Duty 0x400 is the zero-torque midpoint of the 11-bit PWM range.
package mtr_pkg;
   localparam int DUTY_W = 11;
   localparam int SPD_W  = 12;
   localparam logic [DUTY_W-1:0] DUTY_MID   = 11'h400;
   localparam logic [DUTY_W-1:0] PERIOD_MAX = 11'h7FF;
endpackage

// File: rtl/mtr_duty_slew_if.sv
// Command and duty bundle between the motion controller and the duty slew block.
// Duties and at_target are registered outputs of the slave; no backpressure.
interface mtr_duty_slew_if;
   import mtr_pkg::*;

   logic                    en;
   logic                    cmd_vld;
   logic signed [SPD_W-1:0] lft_spd;
   logic signed [SPD_W-1:0] rgt_spd;
   logic [DUTY_W-1:0]       lft_duty;
   logic [DUTY_W-1:0]       rgt_duty;
   logic                    at_target;

   modport master (
      output en, cmd_vld, lft_spd, rgt_spd,
      input  lft_duty, rgt_duty, at_target
   );

   modport slave (
      input  en, cmd_vld, lft_spd, rgt_spd,
      output lft_duty, rgt_duty, at_target
   );
endinterface

// File: rtl/mtr_duty_slew_chan.sv
// One channel: speed-to-target mapping, target register and per-period slew step.
// Target visible one cycle after cmd_vld; duty moves only on the boundary edge.
module slew_chan
   import mtr_pkg::*;
#(
   parameter int STEP = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    cmd_vld,
   input  logic                    bnd,
   input  logic signed [SPD_W-1:0] spd,
   output logic [DUTY_W-1:0]       duty,
   output logic [DUTY_W-1:0]       tgt
);
   localparam logic [SPD_W-1:0]  STEP_S = SPD_W'(STEP);
   localparam logic [DUTY_W-1:0] STEP_D = DUTY_W'(STEP);

   logic [DUTY_W-1:0]       tgt_map;
   logic signed [SPD_W-1:0] diff;
   logic [SPD_W-1:0]        mag;
   logic [DUTY_W-1:0]       duty_nxt;

   // Offset-binary: modulo-2048 add turns -2048 into 0x000 and +2047 into 0x7FF.
   assign tgt_map = DUTY_MID + DUTY_W'(spd >>> 1);

   always_comb begin
      diff     = $signed({1'b0, tgt}) - $signed({1'b0, duty});
      mag      = diff[SPD_W-1] ? SPD_W'(-diff) : SPD_W'(diff);
      duty_nxt = tgt;
      if (mag > STEP_S) begin
         duty_nxt = diff[SPD_W-1] ? (duty - STEP_D) : (duty + STEP_D);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgt  <= DUTY_MID;
         duty <= DUTY_MID;
      end else if (!en) begin
         tgt  <= DUTY_MID;
         duty <= DUTY_MID;
      end else begin
         if (cmd_vld) tgt  <= tgt_map;
         if (bnd)     duty <= duty_nxt;
      end
   end
endmodule

// File: rtl/mtr_duty_slew.sv
// Slew-limited left/right PWM duty generator, updates aligned to the PWM period end.
// Duty steps at most STEP counts per 2048-cycle period; en low forces 0x400 next edge.
module mtr_duty_slew
   import mtr_pkg::*;
#(
   parameter int STEP = 16
) (
   input logic            clk,
   input logic            rst_n,
   mtr_duty_slew_if.slave bus
);
   logic [DUTY_W-1:0] prd_cnt;
   logic              bnd;
   logic [DUTY_W-1:0] lft_tgt;
   logic [DUTY_W-1:0] rgt_tgt;

   // Free-running, never gated by en, so it stays phase-locked to the PWM counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prd_cnt <= '0;
      else        prd_cnt <= prd_cnt + 1'b1;
   end

   assign bnd = (prd_cnt == PERIOD_MAX);

   slew_chan #(.STEP(STEP)) u_lft (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (bus.en),
      .cmd_vld (bus.cmd_vld),
      .bnd     (bnd),
      .spd     (bus.lft_spd),
      .duty    (bus.lft_duty),
      .tgt     (lft_tgt)
   );

   slew_chan #(.STEP(STEP)) u_rgt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (bus.en),
      .cmd_vld (bus.cmd_vld),
      .bnd     (bnd),
      .spd     (bus.rgt_spd),
      .duty    (bus.rgt_duty),
      .tgt     (rgt_tgt)
   );

   assign bus.at_target = (bus.lft_duty == lft_tgt) && (bus.rgt_duty == rgt_tgt);
endmodule

// File: tb/tb_mtr_duty_slew.sv
// Directed bench for mtr_duty_slew; STEP is raised to 64 to keep full-scale ramps short.
module tb_mtr_duty_slew;
   import mtr_pkg::*;

   localparam int STEP_TB = 64;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;
   logic [10:0] tb_cnt;

   mtr_duty_slew_if bus ();

   mtr_duty_slew #(.STEP(STEP_TB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference period counter: 0 from reset, +1 per clock, wraps at 2047.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_cnt <= '0;
      else        tb_cnt <= tb_cnt + 11'd1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Leaves the bench at the negedge where the counter reads 0, just after an update.
   task automatic go_bnd();
      @(negedge clk);
      while (tb_cnt != 11'd0) @(negedge clk);
   endtask

   task automatic pulse(input int l, input int r);
      bus.cmd_vld = 1'b1;
      bus.lft_spd = 12'(l);
      bus.rgt_spd = 12'(r);
      @(negedge clk);
      bus.cmd_vld = 1'b0;
   endtask

   task automatic chk_state(input string tag, input int l, input int r, input int at);
      chk({tag, "_lft"}, int'(bus.lft_duty), l);
      chk({tag, "_rgt"}, int'(bus.rgt_duty), r);
      chk({tag, "_at"},  int'(bus.at_target), at);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.en = 1'b1;
      bus.cmd_vld = 1'b0;
      bus.lft_spd = '0;
      bus.rgt_spd = '0;
      repeat (3) @(negedge clk);
      chk_state("reset", 'h400, 'h400, 1);
      rst_n = 1'b1;

      for (int p = 0; p < 3; p++) begin
         go_bnd();
         chk_state("idle", 'h400, 'h400, 1);
      end

      // +512 left: target 0x500, four boundary steps of 64.
      pulse(512, 0);
      chk_state("up_tgt", 'h400, 'h400, 0);
      for (int k = 1; k <= 4; k++) begin
         go_bnd();
         chk("up_lft", int'(bus.lft_duty), 'h400 + k * STEP_TB);
         chk("up_rgt", int'(bus.rgt_duty), 'h400);
         chk("up_at", int'(bus.at_target), (k == 4) ? 1 : 0);
      end

      // Ramp back toward 0x400 and drop en at 0x480.
      pulse(0, 0);
      go_bnd();
      go_bnd();
      chk("dn_mid", int'(bus.lft_duty), 'h480);
      bus.en = 1'b0;
      @(negedge clk);
      chk_state("en_off", 'h400, 'h400, 1);
      pulse(512, 0);
      chk_state("en_off_cmd", 'h400, 'h400, 1);
      go_bnd();
      chk_state("en_off_bnd", 'h400, 'h400, 1);
      bus.en = 1'b1;
      go_bnd();
      chk_state("en_on_hold", 'h400, 'h400, 1);

      // Residual error of 5 counts closes in one boundary.
      pulse(10, 0);
      chk("rem_at0", int'(bus.at_target), 0);
      go_bnd();
      chk_state("rem", 'h405, 'h400, 1);

      // Full-scale swing from midpoint; right channel ends on a 63-count step.
      bus.en = 1'b0;
      @(negedge clk);
      bus.en = 1'b1;
      pulse(-2048, 2047);
      for (int k = 1; k <= 16; k++) begin
         go_bnd();
         chk("fs_lft", int'(bus.lft_duty), 'h400 - k * STEP_TB);
         chk("fs_rgt", int'(bus.rgt_duty),
             ('h400 + k * STEP_TB > 'h7FF) ? 'h7FF : 'h400 + k * STEP_TB);
         chk("fs_at", int'(bus.at_target), (k == 16) ? 1 : 0);
      end

      // Back-to-back: last command (target 0x040) wins over 0x7FF.
      bus.cmd_vld = 1'b1;
      bus.lft_spd = 12'sd2047;
      bus.rgt_spd = 12'sd2047;
      @(negedge clk);
      bus.lft_spd = -12'sd1920;
      @(negedge clk);
      bus.cmd_vld = 1'b0;
      chk("b2b_at", int'(bus.at_target), 0);

      // Command on the counter==2047 cycle: boundary still uses 0x040, then 0x020.
      while (tb_cnt != 11'h7FF) @(negedge clk);
      pulse(-1984, 2047);
      chk_state("coin_old", 'h040, 'h7FF, 0);
      go_bnd();
      chk_state("coin_new", 'h020, 'h7FF, 1);

      // Asynchronous reset between clock edges.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_state("arst", 'h400, 'h400, 1);
      @(negedge clk);
      rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
